tmds_encoder: RTL

DVI 1.0 TMDS 8b/10b encoder for one channel. It sits between the pixel/timing source (pattern_gen's de, hsync, vsync and 24-bit data) and the 10:1 serializer inside dvi_tx. Three instances are used, one per colour channel. Each cycle it converts an 8-bit data byte, or a 2-bit control code during blanking, into a 10-bit transition-minimised, DC-balanced symbol.

---
 rtl/dvi_pkg.sv | 23 ++
 rtl/tmds_encoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared DVI/TMDS constants and helpers
// Purpose: TMDS control tokens, symbol width and an 8-bit popcount.
//          Used by tmds_encoder and by dvi_tx.
// Ports:   none (package)
package dvi_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] TMDS_CTL_00 = 10'h354;
    localparam logic [TMDS_W-1:0] TMDS_CTL_01 = 10'h0AB;
    localparam logic [TMDS_W-1:0] TMDS_CTL_10 = 10'h154;
    localparam logic [TMDS_W-1:0] TMDS_CTL_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - DVI TMDS 8b/10b encoder, one channel, 2-stage pipeline
// Purpose: converts a pixel byte (in_de = 1) or a control code (in_de = 0)
//          into a transition-minimised, DC-balanced 10-bit symbol.
// Ports:
//   clk    in   pixel clock, rising edge
//   reset  in   synchronous, active-high; clears both stages
//   in_de  in   1 = encode in_d, 0 = emit control token for in_c
//   in_c   in   [1:0] control code
//   in_d   in   [7:0] pixel byte
//   out_d  out  [9:0] TMDS symbol, bit 0 transmitted first
module tmds_encoder
    import dvi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_de,
    input  logic [1:0]        in_c,
    input  logic [7:0]        in_d,
    output logic [TMDS_W-1:0] out_d
);

    // ---------------- stage 1: transition minimisation ----------------
    logic       de_q;
    logic [1:0] c_q;
    logic [8:0] qm_q;
    logic [8:0] qm_d;
    logic [3:0] n1d;
    logic       use_xnor;

    always_comb begin
        n1d      = popcount8(in_d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !in_d[0]);
        qm_d     = 9'd0;
        qm_d[0]  = in_d[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ in_d[i]) : (qm_d[i-1] ^ in_d[i]);
        end
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            de_q <= 1'b0;
            c_q  <= 2'b00;
            qm_q <= 9'd0;
        end else begin
            de_q <= in_de;
            c_q  <= in_c;
            qm_q <= qm_d;
        end
    end

    // ---------------- stage 2: DC balancing ----------------
    logic [TMDS_W-1:0] sym_q;
    logic [TMDS_W-1:0] sym_d;
    logic [TMDS_W-1:0] ctl_sym;
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_d;
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] disp;     // n1 - n0 of q_m[7:0]
    logic signed [4:0] two_q8;   // 2 * q_m[8]
    logic signed [4:0] two_nq8;  // 2 * ~q_m[8]
    logic              cnt_pos;
    logic              cnt_neg;

    always_comb begin
        n1      = popcount8(qm_q[7:0]);
        n0      = 4'd8 - n1;
        // popcounts are unsigned; widen with a zero MSB before subtracting
        disp    = $signed({1'b0, n1}) - $signed({1'b0, n0});
        two_q8  = qm_q[8] ? 5'sd2 : 5'sd0;
        two_nq8 = qm_q[8] ? 5'sd0 : 5'sd2;
        cnt_pos = !cnt_q[4] && (cnt_q != 5'sd0);
        cnt_neg = cnt_q[4];

        if ((cnt_q == 5'sd0) || (n1 == n0)) begin
            sym_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
            cnt_d = qm_q[8] ? (cnt_q + disp) : (cnt_q - disp);
        end else if ((cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1))) begin
            // invert to pull the running disparity back towards zero
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + two_q8 - disp;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + disp - two_nq8;
        end

        case (c_q)
            2'b00:   ctl_sym = TMDS_CTL_00;
            2'b01:   ctl_sym = TMDS_CTL_01;
            2'b10:   ctl_sym = TMDS_CTL_10;
            default: ctl_sym = TMDS_CTL_11;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q <= TMDS_CTL_00;
            cnt_q <= 5'sd0;
        end else if (!de_q) begin
            // blanking restarts disparity so the next burst begins in case A
            sym_q <= ctl_sym;
            cnt_q <= 5'sd0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_d = sym_q;

endmodule
